pwm_duty_meter: RTL and testbench



---
 rtl/pwm_duty_meter.sv | 145 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM receive-side decoder: recovers high-phase length and rise-to-rise period
// of one PWM line, pulses sample_valid per closed period, and flags stuck lines.
module pwm_duty_meter #(
  parameter int PWM_INTERVAL = 1200,
  parameter int TIMEOUT      = 2400,
  parameter bit INVERT       = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pwm_in,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] duty_value,
  output logic [$clog2(TIMEOUT+1)-1:0]      period_value,
  output logic                              sample_valid,
  output logic                              stuck_high,
  output logic                              stuck_low
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] INT_CW  = CW'(PWM_INTERVAL);
  localparam logic [DW-1:0] DUTY_MX = DW'(PWM_INTERVAL);

  typedef enum logic [1:0] {ARM, HIGH, LOW, STUCK} state_t;

  state_t        state, state_nx;
  logic          sync1, sync2, s, s_d;
  logic          rise, fall, timeout;
  logic [CW-1:0] period_cnt, high_cnt, idle_cnt;
  logic [CW-1:0] period_cnt_nx, high_cnt_nx, idle_cnt_nx;
  logic [DW-1:0] duty_nx;
  logic [CW-1:0] period_nx;
  logic          valid_nx, stuck_high_nx, stuck_low_nx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == TMO) ? v : v + ONE;
  endfunction

  // Synchroniser resets to the inactive pin level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      s_d   <= s;
    end
  end

  assign s       = sync2 ^ INVERT;
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign timeout = (state != STUCK) && (idle_cnt == TMO_M1) && !rise && !fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARM;
      period_cnt   <= '0;
      high_cnt     <= '0;
      idle_cnt     <= '0;
      duty_value   <= '0;
      period_value <= '0;
      sample_valid <= 1'b0;
      stuck_high   <= 1'b0;
      stuck_low    <= 1'b0;
    end else begin
      state        <= state_nx;
      period_cnt   <= period_cnt_nx;
      high_cnt     <= high_cnt_nx;
      idle_cnt     <= idle_cnt_nx;
      duty_value   <= duty_nx;
      period_value <= period_nx;
      sample_valid <= valid_nx;
      stuck_high   <= stuck_high_nx;
      stuck_low    <= stuck_low_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    period_cnt_nx = period_cnt;
    high_cnt_nx   = high_cnt;
    idle_cnt_nx   = (rise || fall) ? '0 : sat_inc(idle_cnt);
    duty_nx       = duty_value;
    period_nx     = period_value;
    valid_nx      = 1'b0;
    stuck_high_nx = stuck_high;
    stuck_low_nx  = stuck_low;

    if (timeout) begin
      state_nx      = STUCK;
      stuck_high_nx = s;
      stuck_low_nx  = ~s;
      duty_nx       = s ? DUTY_MX : '0;
      period_nx     = '0;
      valid_nx      = 1'b1;
    end else begin
      unique case (state)
        ARM: begin
          if (rise) begin
            state_nx      = HIGH;
            period_cnt_nx = ONE;
            high_cnt_nx   = ONE;
          end
        end
        HIGH: begin
          period_cnt_nx = sat_inc(period_cnt);
          if (fall) state_nx = LOW;
          else      high_cnt_nx = sat_inc(high_cnt);
        end
        LOW: begin
          if (rise) begin
            duty_nx       = (high_cnt > INT_CW) ? DUTY_MX : DW'(high_cnt);
            period_nx     = period_cnt;
            valid_nx      = 1'b1;
            period_cnt_nx = ONE;
            high_cnt_nx   = ONE;
            state_nx      = HIGH;
          end else begin
            period_cnt_nx = sat_inc(period_cnt);
          end
        end
        STUCK: begin
          if (rise) begin
            state_nx      = HIGH;
            period_cnt_nx = ONE;
            high_cnt_nx   = ONE;
            stuck_high_nx = 1'b0;
            stuck_low_nx  = 1'b0;
          end else if (fall) begin
            state_nx      = ARM;
            stuck_high_nx = 1'b0;
            stuck_low_nx  = 1'b0;
          end
        end
        default: state_nx = ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench: one active-high and one active-low instance fed the same
// logical waveform, compared every cycle against a timestamp-based reference model.
module tb_pwm_duty_meter;

  localparam int PI = 1200;
  localparam int TO = 2400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lvl;
  logic        pwm_a, pwm_b;
  logic [10:0] duty_a, duty_b;
  logic [11:0] period_a, period_b;
  logic        sv_a, sv_b, sh_a, sh_b, sl_a, sl_b;

  assign pwm_a = lvl;
  assign pwm_b = ~lvl;

  always #5 clk = ~clk;

  pwm_duty_meter #(.PWM_INTERVAL(PI), .TIMEOUT(TO), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_a), .duty_value(duty_a), .period_value(period_a),
    .sample_valid(sv_a), .stuck_high(sh_a), .stuck_low(sl_a));

  pwm_duty_meter #(.PWM_INTERVAL(PI), .TIMEOUT(TO), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_b), .duty_value(duty_b), .period_value(period_b),
    .sample_valid(sv_b), .stuck_high(sh_b), .stuck_low(sl_b));

  // Reference model: remembers the logical level seen at every clock edge and
  // the edge numbers of the last rise/fall/any-edge; measurements are differences.
  localparam int M_ARM = 0, M_PER = 1, M_STUCK = 2;
  bit          hist[$];
  int          n, mode, t_rise, t_fall, t_edge;
  logic [10:0] e_duty;
  logic [11:0] e_period;
  logic        e_valid, e_sh, e_sl;

  function automatic bit lv(input int i);
    if (i < 1) return 1'b0;
    return hist[i-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit s, sd;
    if (!rst_n) begin
      hist.delete();
      n = 0; mode = M_ARM; t_rise = 0; t_fall = 0; t_edge = 0;
      e_duty = '0; e_period = '0; e_valid = 1'b0; e_sh = 1'b0; e_sl = 1'b0;
    end else begin
      n++;
      hist.push_back(lvl);
      s  = lv(n - 2);
      sd = lv(n - 3);
      e_valid = 1'b0;
      if (s && !sd) begin
        if (mode == M_PER) begin
          e_duty   = 11'((t_fall - t_rise) > PI ? PI : (t_fall - t_rise));
          e_period = 12'((n - t_rise) > TO ? TO : (n - t_rise));
          e_valid  = 1'b1;
        end
        mode = M_PER; e_sh = 1'b0; e_sl = 1'b0; t_rise = n; t_edge = n;
      end else if (!s && sd) begin
        if (mode == M_STUCK) begin
          mode = M_ARM; e_sh = 1'b0; e_sl = 1'b0;
        end
        t_fall = n; t_edge = n;
      end else if (mode != M_STUCK && (n - t_edge) == TO) begin
        mode = M_STUCK; e_sh = s; e_sl = !s;
        e_duty = s ? 11'(PI) : 11'd0; e_period = '0; e_valid = 1'b1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (sv_a) pulses++;
    chk("cycle_a", int'({sv_a, sh_a, sl_a, duty_a, period_a}),
        int'({e_valid, e_sh, e_sl, e_duty, e_period}));
    chk("cycle_b", int'({sv_b, sh_b, sl_b, duty_b, period_b}),
        int'({e_valid, e_sh, e_sl, e_duty, e_period}));
  endtask

  task automatic drive(input bit v, input int cycles);
    lvl = v;
    repeat (cycles) tick();
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_duty;
    int exp_period;
  } vec_t;

  vec_t vecs[7];
  int   p0;

  initial begin
    vecs[0] = '{300,  900,  3, 300,  1200};
    vecs[1] = '{600,  600,  2, 600,  1200};
    vecs[2] = '{1,    1199, 2, 1,    1200};
    vecs[3] = '{1199, 1,    2, 1199, 1200};
    vecs[4] = '{1200, 100,  2, 1200, 1300};
    vecs[5] = '{1500, 100,  2, 1200, 1600};
    vecs[6] = '{50,   2000, 2, 50,   2050};

    lvl   = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_state_a", int'({sv_a, sh_a, sl_a, duty_a, period_a}), 0);
    chk("reset_state_b", int'({sv_b, sh_b, sl_b, duty_b, period_b}), 0);
    rst_n = 1'b1;

    // Inactive line from reset: single stuck_low report
    p0 = pulses;
    drive(1'b0, 2405);
    chk("stuck_low_a", int'(sl_a), 1);
    chk("stuck_low_b", int'(sl_b), 1);
    chk("stuck_low_duty", int'(duty_a), 0);
    chk("stuck_low_period", int'(period_a), 0);
    chk("stuck_low_pulses", pulses - p0, 1);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(1'b1, vecs[i].hi);
        drive(1'b0, vecs[i].lo);
      end
      chk($sformatf("vec%0d_duty_a", i), int'(duty_a), vecs[i].exp_duty);
      chk($sformatf("vec%0d_duty_b", i), int'(duty_b), vecs[i].exp_duty);
      chk($sformatf("vec%0d_period_a", i), int'(period_a), vecs[i].exp_period);
      chk($sformatf("vec%0d_period_b", i), int'(period_b), vecs[i].exp_period);
      chk($sformatf("vec%0d_flags", i), int'({sh_a, sl_a, sh_b, sl_b}), 0);
    end

    // Held active after valid samples: stuck_high with saturated duty
    drive(1'b1, 2410);
    chk("stuck_high_a", int'(sh_a), 1);
    chk("stuck_high_b", int'(sh_b), 1);
    chk("stuck_high_duty", int'(duty_a), PI);
    chk("stuck_high_period", int'(period_a), 0);
    drive(1'b0, 10);
    chk("stuck_high_release", int'({sh_a, sl_a, sh_b, sl_b}), 0);
    chk("stuck_release_hold_duty", int'(duty_a), PI);

    // Reset asserted mid-HIGH, between clock edges
    drive(1'b1, 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", int'({sv_a, sh_a, sl_a, duty_a, period_a}), 0);
    chk("async_reset_b", int'({sv_b, sh_b, sl_b, duty_b, period_b}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    p0 = pulses;
    drive(1'b1, 200);
    drive(1'b0, 400);
    chk("no_sample_before_2nd_rise", pulses - p0, 0);
    drive(1'b1, 300);
    chk("first_sample_after_reset", pulses - p0, 1);
    chk("post_reset_duty", int'(duty_a), 200);
    chk("post_reset_period", int'(period_a), 600);
    drive(1'b0, 300);

    // Randomised waveform, occasionally long enough to go stuck
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, $urandom_range(1, 1300));
      drive(1'b0, (k == 9) ? 2500 : $urandom_range(1, 1300));
    end
    drive(1'b1, 5);
    drive(1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
